mem_write_sequencer: RTL and testbench

MEM_WRITE_SEQUENCER -- requirements
Module: mem_write_sequencer

---
 rtl/mem_write_sequencer.sv | 124 ++++++++++++
 tb/tb_mem_write_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_sequencer.sv
// Write-port sequencer: clears the RAM to DEFAULT_VALUE, then forwards host writes.
// Ports: clk, reset, clear_req, wr_valid/wr_ready/wr_addr/wr_data, mem_hold, mem_wea/addra/dia, clearing, clear_done, write_count.
module mem_write_sequencer #(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    DEPTH         = 16,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_req,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     mem_hold,
  output logic                     mem_wea,
  output logic [$clog2(DEPTH)-1:0] mem_addra,
  output logic [DATA_WIDTH-1:0]    mem_dia,
  output logic                     clearing,
  output logic                     clear_done,
  output logic [15:0]              write_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         clr_addr_q, clr_addr_d;
  logic                  full_q, full_d;
  logic [AW-1:0]         buf_addr_q, buf_addr_d;
  logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  done_q, done_d;

  logic                  is_run;
  logic                  issue_clr;
  logic                  issue_host;
  logic                  hs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      full_q     <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      full_q     <= full_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    full_d     = full_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;

    is_run     = (state_q == RUN);
    // A clear request blocks both the handshake and the drain of the
    // buffered entry, so that entry is dropped rather than written.
    wr_ready   = is_run && !clear_req && (!full_q || !mem_hold);
    hs         = wr_valid && wr_ready;
    issue_clr  = !is_run && !mem_hold;
    issue_host = is_run && !clear_req && full_q && !mem_hold;

    mem_wea    = issue_clr || issue_host;
    mem_addra  = '0;
    mem_dia    = '0;
    if (issue_clr) begin
      mem_addra = clr_addr_q;
      mem_dia   = DEFAULT_VALUE;
    end else if (issue_host) begin
      mem_addra = buf_addr_q;
      mem_dia   = buf_data_q;
    end

    clearing    = !is_run;
    clear_done  = done_q;
    write_count = cnt_q;

    if (!is_run) begin
      if (clear_req) begin
        clr_addr_d = '0;
      end else if (!mem_hold) begin
        if (clr_addr_q == LAST) begin
          state_d    = RUN;
          clr_addr_d = '0;
          done_d     = 1'b1;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
    end else if (clear_req) begin
      state_d    = CLEAR;
      clr_addr_d = '0;
      full_d     = 1'b0;
    end else begin
      if (issue_host) begin
        cnt_d  = cnt_q + 16'd1;
        full_d = 1'b0;
      end
      // A load in the same cycle as a drain refills the buffer.
      if (hs) begin
        full_d     = 1'b1;
        buf_addr_d = wr_addr;
        buf_data_d = wr_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_write_sequencer.sv
// Directed testbench for mem_write_sequencer (DATA_WIDTH=8, DEPTH=5, DEFAULT_VALUE=A5).
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_mem_write_sequencer;

  localparam logic [7:0] DV = 8'hA5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear_req = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       mem_hold = 1'b0;
  logic       mem_wea;
  logic [2:0] mem_addra;
  logic [7:0] mem_dia;
  logic       clearing;
  logic       clear_done;
  logic [15:0] write_count;

  int total = 0;
  int bad = 0;

  mem_write_sequencer #(
    .DATA_WIDTH(8), .DEPTH(5), .DEFAULT_VALUE(DV)
  ) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_hold(mem_hold), .mem_wea(mem_wea),
    .mem_addra(mem_addra), .mem_dia(mem_dia),
    .clearing(clearing), .clear_done(clear_done),
    .write_count(write_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    #1 reset = 1'b1;
    @(negedge clk); #1;
    total++;
    if ({mem_wea, mem_addra, mem_dia} !== {1'b1, 3'd0, DV}) begin
      bad++;
      $display("FAIL rst_write got %b/%0d/%h want 1/0/a5", mem_wea, mem_addra, mem_dia);
    end
    total++;
    if ({wr_ready, clearing, clear_done, write_count} !== {1'b0, 1'b1, 1'b0, 16'd0}) begin
      bad++;
      $display("FAIL rst_flags got rdy=%b clr=%b done=%b cnt=%0d want 0/1/0/0",
               wr_ready, clearing, clear_done, write_count);
    end
    mem_hold = 1'b1; #1;
    total++;
    if ({mem_wea, mem_addra, mem_dia} !== {1'b0, 3'd0, 8'd0}) begin
      bad++;
      $display("FAIL rst_hold got %b/%0d/%h want 0/0/00", mem_wea, mem_addra, mem_dia);
    end
    @(negedge clk);
    mem_hold = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_clear_seq();
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if ({mem_wea, mem_addra, mem_dia, wr_ready, clearing, clear_done} !==
          {1'b1, 3'(i), DV, 1'b0, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL clr_seq[%0d] got wea=%b a=%0d d=%h rdy=%b clr=%b done=%b want 1/%0d/a5/0/1/0",
                 i, mem_wea, mem_addra, mem_dia, wr_ready, clearing, clear_done, i);
      end
      @(negedge clk);
    end
    #1;
    total++;
    if ({clear_done, clearing, wr_ready, mem_wea} !== 4'b1010) begin
      bad++;
      $display("FAIL clr_done got done=%b clr=%b rdy=%b wea=%b want 1/0/1/0",
               clear_done, clearing, wr_ready, mem_wea);
    end
    @(negedge clk); #1;
    total++;
    if (clear_done !== 1'b0) begin
      bad++;
      $display("FAIL clr_done_pulse got %b want 0", clear_done);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [2:0] a [3];
    logic [7:0] d [3];
    a = '{3'd1, 3'd2, 3'd3};
    d = '{8'h11, 8'h22, 8'h33};
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        wr_valid = 1'b1; wr_addr = a[k]; wr_data = d[k];
      end else begin
        wr_valid = 1'b0;
      end
      #1;
      if (k < 3) begin
        total++;
        if (wr_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_ready[%0d] got %b want 1", k, wr_ready);
        end
      end
      total++;
      if (k == 0) begin
        if ({mem_wea, mem_addra, mem_dia} !== {1'b0, 3'd0, 8'd0}) begin
          bad++;
          $display("FAIL b2b_lat got %b/%0d/%h want 0/0/00", mem_wea, mem_addra, mem_dia);
        end
      end else if ({mem_wea, mem_addra, mem_dia} !== {1'b1, a[k-1], d[k-1]}) begin
        bad++;
        $display("FAIL b2b_wr[%0d] got %b/%0d/%h want 1/%0d/%h",
                 k, mem_wea, mem_addra, mem_dia, a[k-1], d[k-1]);
      end
      @(negedge clk);
    end
    #1;
    total++;
    if ({mem_wea, write_count} !== {1'b0, 16'd3}) begin
      bad++;
      $display("FAIL b2b_count got wea=%b cnt=%0d want 0/3", mem_wea, write_count);
    end
    @(negedge clk);
  endtask

  task automatic test_hold();
    wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 8'h77;
    #1;
    total++;
    if (wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL hold_load got rdy=%b want 1", wr_ready);
    end
    @(negedge clk);
    wr_addr = 3'd3; wr_data = 8'h88;
    mem_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if ({wr_ready, mem_wea, mem_addra, mem_dia} !== {1'b0, 1'b0, 3'd0, 8'd0}) begin
        bad++;
        $display("FAIL hold_stall[%0d] got rdy=%b wea=%b a=%0d d=%h want 0/0/0/00",
                 i, wr_ready, mem_wea, mem_addra, mem_dia);
      end
      @(negedge clk);
    end
    mem_hold = 1'b0; wr_valid = 1'b0;
    #1;
    total++;
    if ({mem_wea, mem_addra, mem_dia} !== {1'b1, 3'd2, 8'h77}) begin
      bad++;
      $display("FAIL hold_release got %b/%0d/%h want 1/2/77", mem_wea, mem_addra, mem_dia);
    end
    @(negedge clk); #1;
    total++;
    if ({mem_wea, write_count} !== {1'b0, 16'd4}) begin
      bad++;
      $display("FAIL hold_once got wea=%b cnt=%0d want 0/4", mem_wea, write_count);
    end
    @(negedge clk);
  endtask

  task automatic test_clear_req();
    wr_valid = 1'b1; wr_addr = 3'd4; wr_data = 8'h44;
    #1;
    total++;
    if (wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL creq_load got rdy=%b want 1", wr_ready);
    end
    @(negedge clk);
    clear_req = 1'b1; wr_addr = 3'd0; wr_data = 8'h99;
    #1;
    total++;
    if ({wr_ready, mem_wea, clearing} !== 3'b000) begin
      bad++;
      $display("FAIL creq_cycle got rdy=%b wea=%b clr=%b want 0/0/0", wr_ready, mem_wea, clearing);
    end
    @(negedge clk);
    clear_req = 1'b0; wr_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if ({mem_wea, mem_addra, mem_dia, clearing} !== {1'b1, 3'(i), DV, 1'b1}) begin
        bad++;
        $display("FAIL creq_clr[%0d] got %b/%0d/%h clr=%b want 1/%0d/a5/1",
                 i, mem_wea, mem_addra, mem_dia, clearing, i);
      end
      @(negedge clk);
    end
    #1;
    total++;
    if ({clear_done, write_count} !== {1'b1, 16'd4}) begin
      bad++;
      $display("FAIL creq_done got done=%b cnt=%0d want 1/4", clear_done, write_count);
    end
    @(negedge clk);
  endtask

  task automatic test_hold_toggle();
    int pat [9];
    int exp_a;
    pat = '{1, 0, 0, 1, 1, 0, 1, 0, 0};
    exp_a = 0;
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    for (int j = 0; j < 9; j++) begin
      mem_hold = pat[j][0];
      #1;
      total++;
      if (pat[j] != 0) begin
        if ({mem_wea, mem_addra, mem_dia} !== {1'b0, 3'd0, 8'd0}) begin
          bad++;
          $display("FAIL tog_hold[%0d] got %b/%0d/%h want 0/0/00", j, mem_wea, mem_addra, mem_dia);
        end
      end else begin
        if ({mem_wea, mem_addra, mem_dia} !== {1'b1, 3'(exp_a), DV}) begin
          bad++;
          $display("FAIL tog_wr[%0d] got %b/%0d/%h want 1/%0d/a5",
                   j, mem_wea, mem_addra, mem_dia, exp_a);
        end
        exp_a++;
      end
      @(negedge clk);
    end
    mem_hold = 1'b0;
    #1;
    total++;
    if ({clear_done, clearing, mem_wea} !== 3'b100) begin
      bad++;
      $display("FAIL tog_done got done=%b clr=%b wea=%b want 1/0/0", clear_done, clearing, mem_wea);
    end
    @(negedge clk);
  endtask

  task automatic test_clear_restart();
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) clear_req = 1'b1;
      #1;
      total++;
      if ({mem_wea, mem_addra} !== {1'b1, 3'(i)}) begin
        bad++;
        $display("FAIL rst_pre[%0d] got %b/%0d want 1/%0d", i, mem_wea, mem_addra, i);
      end
      @(negedge clk);
    end
    clear_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if ({mem_wea, mem_addra, mem_dia} !== {1'b1, 3'(i), DV}) begin
        bad++;
        $display("FAIL restart[%0d] got %b/%0d/%h want 1/%0d/a5", i, mem_wea, mem_addra, mem_dia, i);
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (clear_done !== 1'b1) begin
      bad++;
      $display("FAIL restart_done got %b want 1", clear_done);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 8'h55;
    @(negedge clk);
    wr_valid = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    total++;
    if ({write_count, clearing, wr_ready, clear_done} !== {16'd0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL mid_reset got cnt=%0d clr=%b rdy=%b done=%b want 0/1/0/0",
               write_count, clearing, wr_ready, clear_done);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    total++;
    if ({clear_done, write_count} !== {1'b1, 16'd0}) begin
      bad++;
      $display("FAIL wrap_start got done=%b cnt=%0d want 1/0", clear_done, write_count);
    end
    wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 8'h3c;
    repeat (65536) @(negedge clk);
    wr_valid = 1'b0;
    #1;
    total++;
    if ({mem_wea, write_count} !== {1'b1, 16'hFFFF}) begin
      bad++;
      $display("FAIL wrap_ffff got wea=%b cnt=%h want 1/ffff", mem_wea, write_count);
    end
    @(negedge clk); #1;
    total++;
    if ({mem_wea, write_count} !== {1'b0, 16'h0000}) begin
      bad++;
      $display("FAIL wrap_zero got wea=%b cnt=%h want 0/0000", mem_wea, write_count);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_clear_seq();
    test_back_to_back();
    test_hold();
    test_clear_req();
    test_hold_toggle();
    test_clear_restart();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
